// File: rtl/encryptor_pkg.sv
// Shared types and constants for the DES job arbiter and its helpers.
package encryptor_pkg;

   localparam int DES_BLOCK_W = 64;
   localparam int SYNC_STAGES = 2;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      START,
      WAIT,
      ACK,
      RESP
   } arb_state_t;

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_id_t;

endpackage

// File: rtl/encryptor_arbiter_job_timer.sv
// Saturating up-counter with synchronous clear and a terminal count at TIMEOUT_CYCLES-1.
module job_timer #(
   parameter int TIMEOUT_CYCLES = 255,
   localparam int TIMER_W = $clog2(TIMEOUT_CYCLES)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               enable,
   output logic [TIMER_W-1:0] count,
   output logic               terminal
);

   assign terminal = (count == TIMER_W'(TIMEOUT_CYCLES - 1));

   // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !terminal) begin
         count <= count + TIMER_W'(1);
      end
   end

endmodule

// File: rtl/encryptor_arbiter.sv
// Round-robin two-requester front end that sequences single DES jobs through encryptor_core.
module encryptor_arbiter
   import encryptor_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_a_valid,
   input  logic [DES_BLOCK_W-1:0] req_a_data,
   input  logic                   req_a_encrypt,
   output logic                   req_a_ready,
   input  logic                   req_b_valid,
   input  logic [DES_BLOCK_W-1:0] req_b_data,
   input  logic                   req_b_encrypt,
   output logic                   req_b_ready,
   output logic                   resp_a_valid,
   output logic [DES_BLOCK_W-1:0] resp_a_data,
   output logic                   resp_a_err,
   input  logic                   resp_a_ready,
   output logic                   resp_b_valid,
   output logic [DES_BLOCK_W-1:0] resp_b_data,
   output logic                   resp_b_err,
   input  logic                   resp_b_ready,
   output logic [DES_BLOCK_W-1:0] core_rcv_data,
   output logic                   core_rcv_data_ready,
   output logic                   core_encrypt,
   output logic                   core_handshake_ack,
   input  logic [DES_BLOCK_W-1:0] core_trans_data,
   input  logic                   core_trans_data_ready,
   output logic                   busy,
   output logic                   err_timeout
);

   localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);

   arb_state_t             state;
   arb_state_t             state_next;
   req_id_t                last_grant;
   req_id_t                owner;
   logic [DES_BLOCK_W-1:0] job_data;
   logic                   job_enc;
   logic [DES_BLOCK_W-1:0] resp_reg;
   logic                   resp_err;
   logic                   grant_a;
   logic                   grant_b;
   logic                   accept;
   logic                   owner_ready;
   logic                   setup_done;
   logic [TIMER_W-1:0]     timer;
   logic                   timer_tc;

   // The timer doubles as the SETUP dwell counter before being cleared again in START.
   job_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_job_timer (
      .clk      (clk),
      .rst      (rst),
      .clear    ((state == IDLE) || (state == START)),
      .enable   ((state == SETUP) || (state == WAIT)),
      .count    (timer),
      .terminal (timer_tc)
   );

   assign setup_done  = (timer == TIMER_W'(SYNC_STAGES - 1));
   assign owner_ready = (owner == REQ_A) ? resp_a_ready : resp_b_ready;
   assign accept      = (state == IDLE) && (grant_a || grant_b);
   assign busy        = (state != IDLE);

   // NOTE: every always_comb output gets a default first so no latch can be inferred.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (req_a_valid && req_b_valid) begin
         grant_a = (last_grant == REQ_B);
         grant_b = (last_grant == REQ_A);
      end else begin
         grant_a = req_a_valid;
         grant_b = req_b_valid;
      end
   end

   // Gated by rst so the outputs are zero while reset is held even with requests pending.
   assign req_a_ready = (state == IDLE) && grant_a && !rst;
   assign req_b_ready = (state == IDLE) && grant_b && !rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:  if (accept) state_next = SETUP;
         SETUP: if (setup_done) state_next = START;
         START: state_next = WAIT;
         WAIT:  if (core_trans_data_ready || timer_tc) state_next = ACK;
         ACK:   state_next = RESP;
         RESP:  if (owner_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // NOTE: datapath registers are reset as well, so nothing stale can leak out after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= REQ_B;
         owner      <= REQ_A;
         job_data   <= '0;
         job_enc    <= 1'b0;
         resp_reg   <= '0;
         resp_err   <= 1'b0;
      end else begin
         if (accept) begin
            owner      <= grant_a ? REQ_A : REQ_B;
            last_grant <= grant_a ? REQ_A : REQ_B;
            job_data   <= grant_a ? req_a_data : req_b_data;
            job_enc    <= grant_a ? req_a_encrypt : req_b_encrypt;
         end
         if (state == WAIT) begin
            if (core_trans_data_ready) begin
               resp_reg <= core_trans_data;
               resp_err <= 1'b0;
            end else if (timer_tc) begin
               resp_reg <= '0;
               resp_err <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      core_rcv_data       = '0;
      core_encrypt        = 1'b0;
      core_rcv_data_ready = 1'b0;
      core_handshake_ack  = 1'b0;
      err_timeout         = 1'b0;
      resp_a_valid        = 1'b0;
      resp_a_data         = '0;
      resp_a_err          = 1'b0;
      resp_b_valid        = 1'b0;
      resp_b_data         = '0;
      resp_b_err          = 1'b0;
      if (state inside {SETUP, START, WAIT, ACK}) begin
         core_rcv_data = job_data;
         core_encrypt  = job_enc;
      end
      core_rcv_data_ready = (state == START);
      core_handshake_ack  = (state == ACK);
      err_timeout         = (state == WAIT) && timer_tc && !core_trans_data_ready;
      if (state == RESP) begin
         if (owner == REQ_A) begin
            resp_a_valid = 1'b1;
            resp_a_data  = resp_reg;
            resp_a_err   = resp_err;
         end else begin
            resp_b_valid = 1'b1;
            resp_b_data  = resp_reg;
            resp_b_err   = resp_err;
         end
      end
   end

endmodule

// File: tb/tb_encryptor_arbiter.sv
// Directed bench for encryptor_arbiter with a behavioural encryptor_core stand-in.
module tb_encryptor_arbiter;

   logic        clk;
   logic        rst;
   logic        req_a_valid, req_b_valid;
   logic [63:0] req_a_data, req_b_data;
   logic        req_a_encrypt, req_b_encrypt;
   logic        req_a_ready, req_b_ready;
   logic        resp_a_valid, resp_b_valid;
   logic [63:0] resp_a_data, resp_b_data;
   logic        resp_a_err, resp_b_err;
   logic        resp_a_ready, resp_b_ready;
   logic [63:0] core_rcv_data;
   logic        core_rcv_data_ready;
   logic        core_encrypt;
   logic        core_handshake_ack;
   logic [63:0] core_trans_data;
   logic        core_trans_data_ready;
   logic        busy;
   logic        err_timeout;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          t_acc;

   // Core stand-in controls: latency after the start pulse (-1 = never answers) and result.
   int          core_lat = -1;
   logic [63:0] core_result = '0;
   int          core_cnt = 0;
   bit          core_pending = 0;
   int          tdr_cyc = 0;
   logic [63:0] core_got_data = '0;
   logic        core_got_enc = 1'b0;

   encryptor_arbiter #(
      .TIMEOUT_CYCLES(64)
   ) dut (
      .clk                   (clk),
      .rst                   (rst),
      .req_a_valid           (req_a_valid),
      .req_a_data            (req_a_data),
      .req_a_encrypt         (req_a_encrypt),
      .req_a_ready           (req_a_ready),
      .req_b_valid           (req_b_valid),
      .req_b_data            (req_b_data),
      .req_b_encrypt         (req_b_encrypt),
      .req_b_ready           (req_b_ready),
      .resp_a_valid          (resp_a_valid),
      .resp_a_data           (resp_a_data),
      .resp_a_err            (resp_a_err),
      .resp_a_ready          (resp_a_ready),
      .resp_b_valid          (resp_b_valid),
      .resp_b_data           (resp_b_data),
      .resp_b_err            (resp_b_err),
      .resp_b_ready          (resp_b_ready),
      .core_rcv_data         (core_rcv_data),
      .core_rcv_data_ready   (core_rcv_data_ready),
      .core_encrypt          (core_encrypt),
      .core_handshake_ack    (core_handshake_ack),
      .core_trans_data       (core_trans_data),
      .core_trans_data_ready (core_trans_data_ready),
      .busy                  (busy),
      .err_timeout           (err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Core model acts on the falling edge; the bench samples 1 time unit later.
   always @(negedge clk) begin
      if (rst) begin
         core_pending          = 0;
         core_trans_data_ready = 1'b0;
         core_trans_data       = '0;
      end else begin
         if (core_handshake_ack) begin
            core_trans_data_ready = 1'b0;
            core_trans_data       = '0;
            core_pending          = 0;
         end
         if (core_rcv_data_ready) begin
            core_got_data = core_rcv_data;
            core_got_enc  = core_encrypt;
            core_pending  = (core_lat >= 0);
            core_cnt      = core_lat;
         end else if (core_pending && !core_trans_data_ready) begin
            core_cnt = core_cnt - 1;
            if (core_cnt == 0) begin
               core_trans_data_ready = 1'b1;
               core_trans_data       = core_result;
               core_pending          = 0;
               tdr_cyc               = cyc;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   function automatic logic [63:0] ctrl_outs();
      return 64'({busy, err_timeout, req_a_ready, req_b_ready, resp_a_valid, resp_b_valid,
                  resp_a_err, resp_b_err, core_rcv_data_ready, core_encrypt, core_handshake_ack});
   endfunction

   // One tie-break job: both requesters valid, exp_b selects the expected winner.
   task automatic run_tie(input bit exp_b, input logic [63:0] res, input string tag);
      int  bad_other;
      bit  seen;
      core_result = res;
      check({tag, "_grant_a"}, 64'(req_a_ready), 64'(!exp_b));
      check({tag, "_grant_b"}, 64'(req_b_ready), 64'(exp_b));
      step();
      bad_other = 0;
      seen      = 0;
      for (int i = 0; i < 40; i++) begin
         if (exp_b ? resp_a_valid : resp_b_valid) bad_other++;
         if (req_a_ready || req_b_ready) bad_other++;
         if (exp_b ? resp_b_valid : resp_a_valid) begin
            seen = 1;
            break;
         end
         step();
      end
      check({tag, "_resp_seen"}, 64'(seen), 64'd1);
      check({tag, "_other_quiet"}, 64'(bad_other), 64'd0);
      check({tag, "_resp_data"}, exp_b ? resp_b_data : resp_a_data, res);
      check({tag, "_core_in"}, core_got_data, exp_b ? req_b_data : req_a_data);
      if (exp_b) resp_b_ready = 1'b1;
      else       resp_a_ready = 1'b1;
      step();
      resp_a_ready = 1'b0;
      resp_b_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  cnt;
      bit  seen;
      rst           = 1'b1;
      req_a_valid   = 1'b0;
      req_b_valid   = 1'b0;
      req_a_data    = '0;
      req_b_data    = '0;
      req_a_encrypt = 1'b0;
      req_b_encrypt = 1'b0;
      resp_a_ready  = 1'b0;
      resp_b_ready  = 1'b0;
      repeat (3) step();
      check("reset_ctrl", ctrl_outs(), 64'd0);
      check("reset_data", resp_a_data | resp_b_data | core_rcv_data, 64'd0);
      rst = 1'b0;
      step();

      // Single encrypt job from A, core answers 50 cycles after the start pulse.
      core_lat      = 50;
      core_result   = 64'h85E813540F0AB405;
      req_a_data    = 64'h0123456789ABCDEF;
      req_a_encrypt = 1'b1;
      req_a_valid   = 1'b1;
      #0;
      check("t1_a_ready", 64'(req_a_ready), 64'd1);
      check("t1_b_ready", 64'(req_b_ready), 64'd0);
      t_acc = cyc;
      step();
      check("t1_setup_ready_low", 64'(req_a_ready), 64'd0);
      check("t1_setup_enc", 64'(core_encrypt), 64'd1);
      check("t1_setup_data", core_rcv_data, 64'h0123456789ABCDEF);
      check("t1_setup_start", 64'(core_rcv_data_ready), 64'd0);
      req_a_valid = 1'b0;
      step();
      check("t1_setup2_start", 64'(core_rcv_data_ready), 64'd0);
      step();
      check("t1_start_pulse", 64'(core_rcv_data_ready), 64'd1);
      step();
      check("t1_start_done", 64'(core_rcv_data_ready), 64'd0);
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         if (core_handshake_ack) begin
            seen = 1;
            break;
         end
         step();
      end
      check("t1_ack_seen", 64'(seen), 64'd1);
      check("t1_ack_after_tdr", 64'(cyc - tdr_cyc), 64'd1);
      check("t1_ack_cycle", 64'(cyc - t_acc), 64'd54);
      check("t1_core_enc", 64'(core_got_enc), 64'd1);
      step();
      check("t1_resp_valid", 64'(resp_a_valid), 64'd1);
      check("t1_resp_data", resp_a_data, 64'h85E813540F0AB405);
      check("t1_resp_err", 64'(resp_a_err), 64'd0);
      check("t1_resp_b_quiet", 64'(resp_b_valid), 64'd0);
      resp_a_ready = 1'b1;
      step();
      resp_a_ready = 1'b0;
      check("t1_idle", 64'(busy), 64'd0);
      check("t1_resp_dropped", 64'(resp_a_valid), 64'd0);

      // Tie arbitration: a fresh tie-break state still has A's last grant at... B from reset? No:
      // A just won, so the first tie now goes to B; then alternate.
      core_lat      = 3;
      req_a_data    = 64'hAAAA_0000_1111_2222;
      req_b_data    = 64'hBBBB_3333_4444_5555;
      req_a_encrypt = 1'b0;
      req_b_encrypt = 1'b1;
      req_a_valid   = 1'b1;
      req_b_valid   = 1'b1;
      #0;
      run_tie(1'b1, 64'h0000_0000_0000_00B1, "tie1");
      run_tie(1'b0, 64'h0000_0000_0000_00A2, "tie2");
      run_tie(1'b1, 64'h0000_0000_0000_00B3, "tie3");
      run_tie(1'b0, 64'h0000_0000_0000_00A4, "tie4");
      req_a_valid = 1'b0;
      req_b_valid = 1'b0;

      // Response stall: A's result held 20 cycles while B waits; B's ready is ignored.
      core_lat    = 5;
      core_result = 64'hC0FFEE00C0FFEE00;
      req_a_data  = 64'h1234_5678_9ABC_DEF0;
      req_a_valid = 1'b1;
      #0;
      check("t3_a_ready", 64'(req_a_ready), 64'd1);
      step();
      req_a_valid = 1'b0;
      req_b_valid = 1'b1;
      req_b_data  = 64'hFEDC_BA98_7654_3210;
      cnt  = 0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (req_b_ready) cnt++;
         if (resp_a_valid) begin
            seen = 1;
            break;
         end
         step();
      end
      check("t3_resp_seen", 64'(seen), 64'd1);
      resp_b_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (req_b_ready || !resp_a_valid || resp_b_valid) cnt++;
         step();
      end
      check("t3_stall_hold", 64'(cnt), 64'd0);
      check("t3_still_valid", 64'(resp_a_valid), 64'd1);
      check("t3_resp_data", resp_a_data, 64'hC0FFEE00C0FFEE00);
      resp_a_ready = 1'b1;
      #0;
      check("t3_b_wait_in_resp", 64'(req_b_ready), 64'd0);
      step();
      resp_a_ready = 1'b0;
      check("t3_b_granted", 64'(req_b_ready), 64'd1);
      core_result = 64'h5A5A_5A5A_A5A5_A5A5;
      step();
      req_b_valid = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (resp_b_valid) begin
            seen = 1;
            break;
         end
         step();
      end
      check("t3_b_resp_seen", 64'(seen), 64'd1);
      check("t3_b_resp_data", resp_b_data, 64'h5A5A_5A5A_A5A5_A5A5);
      step();
      resp_b_ready = 1'b0;
      check("t3_b_idle", 64'(busy), 64'd0);

      // Timeout: core never answers.
      core_lat    = -1;
      req_a_data  = 64'h0F0F_0F0F_0F0F_0F0F;
      req_a_valid = 1'b1;
      #0;
      check("t4_a_ready", 64'(req_a_ready), 64'd1);
      t_acc = cyc;
      step();
      req_a_valid = 1'b0;
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         if (err_timeout) begin
            seen = 1;
            break;
         end
         step();
      end
      check("t4_timeout_seen", 64'(seen), 64'd1);
      check("t4_timeout_cycle", 64'(cyc - t_acc), 64'd67);
      step();
      check("t4_ack", 64'(core_handshake_ack), 64'd1);
      check("t4_timeout_pulse_end", 64'(err_timeout), 64'd0);
      step();
      check("t4_resp_valid", 64'(resp_a_valid), 64'd1);
      check("t4_resp_err", 64'(resp_a_err), 64'd1);
      check("t4_resp_data", resp_a_data, 64'd0);
      resp_a_ready = 1'b1;
      step();
      resp_a_ready = 1'b0;

      // Boundary: data arrives exactly on the timeout cycle and wins.
      core_lat    = 64;
      core_result = 64'hDEAD_BEEF_0BAD_F00D;
      req_a_data  = 64'h7777_8888_9999_AAAA;
      req_a_valid = 1'b1;
      #0;
      t_acc = cyc;
      step();
      req_a_valid = 1'b0;
      cnt  = 0;
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         if (err_timeout) cnt++;
         if (core_handshake_ack) begin
            seen = 1;
            break;
         end
         step();
      end
      check("t5_ack_seen", 64'(seen), 64'd1);
      check("t5_tdr_cycle", 64'(tdr_cyc - t_acc), 64'd67);
      check("t5_ack_cycle", 64'(cyc - t_acc), 64'd68);
      check("t5_no_timeout", 64'(cnt), 64'd0);
      step();
      check("t5_resp_err", 64'(resp_a_err), 64'd0);
      check("t5_resp_data", resp_a_data, 64'hDEAD_BEEF_0BAD_F00D);
      resp_a_ready = 1'b1;
      step();
      resp_a_ready = 1'b0;

      // Reset mid-WAIT: outputs clear asynchronously, tie history returns to A-first.
      core_lat    = -1;
      req_a_valid = 1'b1;
      step();
      req_a_valid = 1'b0;
      repeat (10) step();
      check("t6_in_wait", 64'(busy), 64'd1);
      req_a_valid = 1'b1;
      req_b_valid = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      check("t6_async_ctrl", ctrl_outs(), 64'd0);
      check("t6_async_data", resp_a_data | resp_b_data | core_rcv_data, 64'd0);
      step();
      rst = 1'b0;
      #0;
      check("t6_tie_a", 64'(req_a_ready), 64'd1);
      check("t6_tie_b", 64'(req_b_ready), 64'd0);
      req_a_valid = 1'b0;
      req_b_valid = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
